uctl_cc_arb: RTL

UCTL_CC_ARB -- requirements
Module: uctl_cc_arb

---
 rtl/uctl_cc_pkg.sv | 27 ++
 rtl/uctl_cc_arb_if.sv | 21 ++
 rtl/uctl_cc_rr_pick.sv | 25 ++
 rtl/uctl_cc_arb.sv | 102 ++++++++++
 4 files changed

// File: rtl/uctl_cc_pkg.sv
// Shared types and constants for the four-client memory arbiter.
package uctl_cc_pkg;

  localparam int NUM_CL = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam logic [3:0] CS_NONE = 4'b0000;
  localparam logic [3:0] CS_CL0  = 4'b0001;
  localparam logic [3:0] CS_CL1  = 4'b0010;
  localparam logic [3:0] CS_CL2  = 4'b0100;
  localparam logic [3:0] CS_CL3  = 4'b1000;

  // Index of a one-hot client select; zero when the vector is not one-hot.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    case (oh)
      CS_CL1:  onehot_to_idx = 2'd1;
      CS_CL2:  onehot_to_idx = 2'd2;
      CS_CL3:  onehot_to_idx = 2'd3;
      default: onehot_to_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/uctl_cc_arb_if.sv
// Client request / memory mux select bundle between the clients and uctl_cc_arb.
interface uctl_cc_arb_if;
  import uctl_cc_pkg::*;

  logic [NUM_CL-1:0] uctl_clReq;
  logic [NUM_CL-1:0] uctl_rdDVl;
  logic [NUM_CL-1:0] uctl_chipsel;
  logic              uctl_busy;
  logic              uctl_ackErr;

  modport master (
    output uctl_clReq, uctl_rdDVl,
    input  uctl_chipsel, uctl_busy, uctl_ackErr
  );

  modport slave (
    input  uctl_clReq, uctl_rdDVl,
    output uctl_chipsel, uctl_busy, uctl_ackErr
  );

endinterface

// File: rtl/uctl_cc_rr_pick.sv
// Combinational rotate-priority picker: first requester after ptr wins.
module uctl_cc_rr_pick
  import uctl_cc_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       valid
);

  logic [1:0] idx;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    gnt = CS_NONE;
    idx = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (gnt == CS_NONE && req[idx]) gnt[idx] = 1'b1;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/uctl_cc_arb.sv
// Round-robin burst arbiter driving a one-hot memory mux select.
// Define UCTL_CC_ARB_PRIO0_EN to give client 0 priority at every arbitration point.
module uctl_cc_arb #(
  parameter int NUM_CL    = 4,
  parameter int MAX_BURST = 8
) (
  input  logic          uctl_clk,
  input  logic          uctl_core_rst,
  uctl_cc_arb_if.slave  bus
);
  import uctl_cc_pkg::*;

  localparam int            BW        = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  arb_state_e        state_q;
  logic [NUM_CL-1:0] req_q;
  logic [NUM_CL-1:0] chipsel_q;
  logic [NUM_CL-1:0] cs_dly_q;
  logic [1:0]        rr_ptr_q;
  logic [BW-1:0]     burst_q;
  logic [BW-1:0]     burst_d;
  logic              ack_err_q;

  logic              holder_req;
  logic              at_limit;
  logic              release_pt;
  logic [3:0]        cand;
  logic [3:0]        rr_gnt;
  logic              rr_valid;
  logic [3:0]        win_gnt;

  assign burst_d    = burst_q + 1'b1;
  assign holder_req = |(req_q & chipsel_q);
  assign at_limit   = (state_q == ST_GRANT) && (burst_d == BURST_MAX);
  assign release_pt = (state_q == ST_GRANT) && (!holder_req || at_limit);

  // At the burst limit the holder is excluded so a waiting client always takes over.
  assign cand = req_q & ~(at_limit ? chipsel_q : CS_NONE);

  uctl_cc_rr_pick u_pick (
    .req   (cand),
    .ptr   (rr_ptr_q),
    .gnt   (rr_gnt),
    .valid (rr_valid)
  );

`ifdef UCTL_CC_ARB_PRIO0_EN
  assign win_gnt = cand[0] ? CS_CL0 : rr_gnt;
`else
  assign win_gnt = rr_gnt;
`endif

  always_ff @(posedge uctl_clk) begin
    // NOTE: reset is sampled on the clock edge, and all state uses non-blocking updates.
    if (uctl_core_rst) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      chipsel_q <= CS_NONE;
      cs_dly_q  <= '0;
      rr_ptr_q  <= 2'd3;
      burst_q   <= '0;
      ack_err_q <= 1'b0;
    end else begin
      req_q    <= bus.uctl_clReq;
      cs_dly_q <= chipsel_q;
      if (bus.uctl_rdDVl != cs_dly_q) ack_err_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (rr_valid) begin
            state_q   <= ST_GRANT;
            chipsel_q <= win_gnt;
            rr_ptr_q  <= onehot_to_idx(win_gnt);
            burst_q   <= '0;
          end
        end
        ST_GRANT: begin
          if (!release_pt) begin
            burst_q <= burst_d;
          end else if (rr_valid) begin
            chipsel_q <= win_gnt;
            rr_ptr_q  <= onehot_to_idx(win_gnt);
            burst_q   <= '0;
          end else if (!holder_req) begin
            state_q   <= ST_IDLE;
            chipsel_q <= CS_NONE;
            burst_q   <= '0;
          end else begin
            // Limit reached with nobody waiting: holder keeps the bus, fresh burst.
            burst_q <= '0;
          end
        end
      endcase
    end
  end

  assign bus.uctl_chipsel = chipsel_q;
  assign bus.uctl_busy    = |chipsel_q;
  assign bus.uctl_ackErr  = ack_err_q;

endmodule
